nonce_scan_scheduler: RTL
=========================

// Module: nonce_scan_scheduler
// PURPOSE
//  Successor to the single-shot work echo path: latches a 640-bit work unit, sweeps the nonce space
//  across NUM_LANES parallel hash lanes, maps lane hit flags back to absolute nonces and queues
//  them in a result FIFO for the serial reporter. Sits between the UART work decoder and the hash cores.
// PARAMETERS
//  NUM_LANES     4   hash lanes fed per issue; power of two, 1..16
//  PIPE_LATENCY  64  fixed cycles from issue to lane_hit for that issue; >=1
//  FIFO_DEPTH    8   result FIFO entries; power of two, >=2
// PORTS
//  clk            in   1    system clock
//  rst_n          in   1    asynchronous active-low reset
//  new_work       in   1    1-cycle strobe: work_data valid
//  work_data      in   640  block header; nonce field [639:608]
//  issue_ready    in   1    lanes accept an issue this cycle
//  issue_valid    out  1    issue_base/issue_header valid
//  issue_header   out  608  work_data[607:0] of the active work
//  issue_base     out  32   nonce for lane 0; lane i hashes issue_base+i
//  lane_hit       in   NUM_LANES  hit flags, PIPE_LATENCY cycles after the matching issue
//  result_valid   out  1    FIFO head valid
//  result_ready   in   1    consumer pops head
//  result_data    out  32   winning nonce
//  busy           out  1    state != IDLE
//  scan_done      out  1    1-cycle pulse when a sweep completes fully drained
//  drop_cnt       out  16   saturating count of lost hits
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, delay line invalid, active-work registers cleared.
//  FSM: IDLE -new_work-> SCAN -last group issued-> DRAIN -PIPE_LATENCY cycles-> DONE -> IDLE.
//  new_work in any state: latch header, base = nonce & ~(NUM_LANES-1), invalidate all in-flight
//   delay-line entries, next state SCAN; FIFO contents are kept. Issue starts next cycle.
//  SCAN: issue_valid=1; on issue_valid&issue_ready base += NUM_LANES; no fire -> base held.
//   Last group: base == 2^32-NUM_LANES; after it fires -> DRAIN (no wrap, no re-issue).
//  Delay line: PIPE_LATENCY-deep shift of {valid, base}; shifts every cycle; valid=fire.
//   lane_hit sampled only when the tail entry is valid; otherwise ignored.
//  Hit mapping: nonce = tail_base + index of lowest set lane_hit bit (32-bit). Extra bits in the
//   same cycle -> drop_cnt += popcount-1. FIFO full on push (after same-cycle pop) -> drop_cnt += 1.
//  drop_cnt saturates at 16'hFFFF; cleared only by reset.
//  DRAIN: counts PIPE_LATENCY cycles so the last group's hits are collected; DONE pulses scan_done.
//  FIFO: first-word-fall-through; pop when result_valid&result_ready; simultaneous push+pop when
//   full succeeds (no drop). Push-to-result_valid latency 1 cycle.
//  Async reset mid-scan: everything returns to reset values immediately; no result emitted.
// CONFIGURATION
//  NONCE_SCAN_STATS_EN defined: adds out port hash_cnt[47:0] = total nonces issued
//   (+NUM_LANES per fire), wrapping, cleared by reset and by new_work.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package nonce_scan_pkg: FSM state enum (IDLE,SCAN,DRAIN,DONE), NONCE_W=32,
//   WORK_W=640, HEADER_W=608, NONCE_LSB=608 constants.
//  Sub-module nonce_result_fifo (width 32, depth FIFO_DEPTH, full/empty, FWFT).
//  Delay line, priority encoder, popcount and FSM stay in the top.
// TESTING
//  NUM_LANES=4,PIPE_LATENCY=4: new_work nonce 0x00000013, ready=1 -> bases 0x10,0x14,0x18...
//  Hit 4'b0100 on tail of base 0x18 -> result_data 0x0000001A, drop_cnt 0.
//  Hit 4'b1011 same cycle -> one result (base+0), drop_cnt +2.
//  nonce 0xFFFFFFF5 -> issues 0xFFFFFFF4,0xFFFFFFF8,0xFFFFFFFC; DRAIN 4 cycles; scan_done 1 cycle.
//  FIFO_DEPTH=2, result_ready=0, 3 hits -> 2 queued, drop_cnt=1; then pop+push while full -> no drop.
//  new_work during SCAN with hits pending -> stale hits ignored; rst_n low mid-scan -> all outputs 0.

Source files
------------

// File: rtl/nonce_scan_pkg.sv
// rtl/nonce_scan_pkg.sv - shared widths and FSM state type for the nonce scan scheduler
package nonce_scan_pkg;

   localparam int NONCE_W   = 32;
   localparam int WORK_W    = 640;
   localparam int HEADER_W  = 608;
   localparam int NONCE_LSB = 608;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } scan_state_t;

endpackage

// File: rtl/nonce_result_fifo.sv
// rtl/nonce_result_fifo.sv - first-word-fall-through result FIFO, push allowed while full if popping
module nonce_result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_en;
   logic             rd_en;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en     = pop && !empty;
   assign wr_en     = push && (!full || pop);
   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are don't-care while empty, so no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/nonce_scan_scheduler.sv
// rtl/nonce_scan_scheduler.sv - sweeps nonce space over parallel lanes and queues hits; NONCE_SCAN_STATS_EN adds hash_cnt
module nonce_scan_scheduler
   import nonce_scan_pkg::*;
#(
   parameter int NUM_LANES    = 4,
   parameter int PIPE_LATENCY = 64,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 new_work,
   input  logic [WORK_W-1:0]    work_data,
   input  logic                 issue_ready,
   output logic                 issue_valid,
   output logic [HEADER_W-1:0]  issue_header,
   output logic [NONCE_W-1:0]   issue_base,
   input  logic [NUM_LANES-1:0] lane_hit,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic [NONCE_W-1:0]   result_data,
   output logic                 busy,
   output logic                 scan_done,
`ifdef NONCE_SCAN_STATS_EN
   output logic [47:0]          hash_cnt,
`endif
   output logic [15:0]          drop_cnt
);

   localparam int                 CNT_W     = $clog2(PIPE_LATENCY + 1);
   localparam logic [NONCE_W-1:0] LANE_MASK = ~NONCE_W'(NUM_LANES - 1);
   localparam logic [NONCE_W-1:0] LAST_BASE = ~NONCE_W'(NUM_LANES - 1);
   localparam logic [NONCE_W-1:0] LANE_STEP = NONCE_W'(NUM_LANES);

   scan_state_t          state;
   scan_state_t          state_nxt;
   logic [HEADER_W-1:0]  header_q;
   logic [NONCE_W-1:0]   base_q;
   logic [CNT_W-1:0]     drain_cnt;
   logic                 fire;
   logic                 last_group;

   logic [PIPE_LATENCY-1:0] dl_valid;
   logic [NONCE_W-1:0]      dl_base [PIPE_LATENCY];
   logic                    tail_valid;
   logic [NONCE_W-1:0]      tail_base;

   logic [NONCE_W-1:0]   hit_idx;
   logic [4:0]           hit_cnt;
   logic                 hit_take;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 full_drop;
   logic [5:0]           drop_add;
   logic [16:0]          drop_sum;

   assign fire         = issue_valid && issue_ready;
   assign last_group   = (base_q == LAST_BASE);
   assign issue_header = header_q;
   assign issue_base   = base_q;
   assign tail_valid   = dl_valid[PIPE_LATENCY-1];
   assign tail_base    = dl_base[PIPE_LATENCY-1];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state and state-decoded outputs; new work restarts the sweep from any state
   always_comb begin
      state_nxt   = state;
      issue_valid = 1'b0;
      busy        = 1'b1;
      scan_done   = 1'b0;
      case (state)
         IDLE:    busy = 1'b0;
         SCAN: begin
            issue_valid = 1'b1;
            if (issue_ready && last_group) state_nxt = DRAIN;
         end
         DRAIN:   if (drain_cnt == CNT_W'(PIPE_LATENCY - 1)) state_nxt = DONE;
         DONE: begin
            scan_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (new_work) state_nxt = SCAN;
   end

   // Active work registers: latched header, lane-0 nonce, drain cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         header_q  <= '0;
         base_q    <= '0;
         drain_cnt <= '0;
      end else if (new_work) begin
         header_q  <= work_data[HEADER_W-1:0];
         base_q    <= work_data[WORK_W-1:NONCE_LSB] & LANE_MASK;
         drain_cnt <= '0;
      end else begin
         if (fire && !last_group) base_q <= base_q + LANE_STEP;
         if (state == DRAIN) drain_cnt <= drain_cnt + CNT_W'(1);
         else                drain_cnt <= '0;
      end
   end

   // Delay line tracking which base each returning lane_hit belongs to; new work flushes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_valid <= '0;
         for (int i = 0; i < PIPE_LATENCY; i++) dl_base[i] <= '0;
      end else begin
         for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_base[i]  <= dl_base[i-1];
         end
         dl_valid[0] <= fire && !new_work;
         dl_base[0]  <= base_q;
         if (new_work) dl_valid <= '0;
      end
   end

   // Lowest set lane wins; remaining set lanes and FIFO overflow count as drops
   always_comb begin
      hit_idx = '0;
      hit_cnt = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (lane_hit[i]) hit_idx = NONCE_W'(i);
      end
      for (int i = 0; i < NUM_LANES; i++) begin
         hit_cnt = hit_cnt + 5'(lane_hit[i]);
      end
      hit_take  = tail_valid && !new_work && (|lane_hit);
      fifo_push = hit_take;
      fifo_pop  = result_valid && result_ready;
      full_drop = fifo_push && fifo_full && !fifo_pop;
      drop_add  = (hit_take ? (6'(hit_cnt) - 6'd1) : 6'd0) + 6'(full_drop);
      drop_sum  = 17'(drop_cnt) + 17'(drop_add);
   end

   // Saturating lost-hit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           drop_cnt <= '0;
      else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
      else                  drop_cnt <= drop_sum[15:0];
   end

`ifdef NONCE_SCAN_STATS_EN
   // Total nonces handed to the lanes for the current work unit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        hash_cnt <= '0;
      else if (new_work) hash_cnt <= '0;
      else if (fire)     hash_cnt <= hash_cnt + 48'(NUM_LANES);
   end
`endif

   assign result_valid = !fifo_empty;

   nonce_result_fifo #(
      .WIDTH (NONCE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (tail_base + hit_idx),
      .pop       (fifo_pop),
      .head_data (result_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
